// File: rtl/laplacian_pkg.sv
// ---------------------------------------------------------------------------
// laplacian_pkg
//   Shared definitions for the 3x3 Laplacian convolution pipeline.
//   - lap_mode_e : kernel select (4-neighbour / 8-neighbour)
//   - STAGES     : pipeline depth, accept to out_valid
//   - lap_out_w  : result port width for the active build
// Build option: LAPLACE_SAT_EN (result clamped to the unsigned pixel range).
// ---------------------------------------------------------------------------
package laplacian_pkg;

  typedef enum logic {
    LAP_MODE4 = 1'b0,
    LAP_MODE8 = 1'b1
  } lap_mode_e;

  localparam int STAGES = 4;

  // Clamped builds return a pixel-sized result; exact builds need +/-8*max.
  function automatic int lap_out_w(input int data_w);
`ifdef LAPLACE_SAT_EN
    return data_w;
`else
    return data_w + 5;
`endif
  endfunction

endpackage

// File: rtl/laplacian_conv_pipe_sum4.sv
// ---------------------------------------------------------------------------
// laplacian_sum4
//   Registered 4-input unsigned adder used for the neighbour partial sums.
// Ports
//   clk, rst_n          clock, async active-low reset
//   en_i                load enable (pipeline advance)
//   a_i, b_i, c_i, d_i  unsigned operands, DATA_W bits
//   sum_o               registered sum, DATA_W+2 bits (never overflows)
// ---------------------------------------------------------------------------
module laplacian_sum4 #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W+1:0] sum_o
);

  logic [DATA_W+1:0] sum_d;
  logic [DATA_W+1:0] sum_q;

  assign sum_d = {2'b00, a_i} + {2'b00, b_i} + {2'b00, c_i} + {2'b00, d_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/laplacian_conv_pipe.sv
// ---------------------------------------------------------------------------
// laplacian_conv_pipe
//   Four-stage 3x3 Laplacian convolution engine, one window per beat.
//     S1: capture neighbours, mode and the scaled centre (x4 or x8)
//     S2: two registered partial neighbour sums (corners zeroed in 4-neighbour mode)
//     S3: neighbour total and subtraction from the scaled centre
//     S4: output register (optionally clamped)
//   A single global advance (adv = !out_valid | out_ready) stalls every stage,
//   so the output holds and nothing is dropped or duplicated under backpressure.
// Ports
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   window handshake; in_ready == adv
//   in_mode               0 = 4-neighbour, 1 = 8-neighbour, travels with the window
//   in_win                9 pixels row-major, p[4] is the centre
//   out_valid / out_ready result handshake
//   out_data              signed exact result, or clamped unsigned pixel
// Build option: LAPLACE_SAT_EN clamps the result to [0, 2^DATA_W-1].
// ---------------------------------------------------------------------------
module laplacian_conv_pipe
  import laplacian_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_mode,
  input  logic [9*DATA_W-1:0]                in_win,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [lap_out_w(DATA_W)-1:0]       out_data
);

  localparam int OUT_W = DATA_W + 5;
  localparam int RES_W = lap_out_w(DATA_W);
  localparam int SUM_W = DATA_W + 2;
  localparam int CEN_W = DATA_W + 3;

  logic              adv;
  logic [STAGES-1:0] vld_q;

  // --- S1 ------------------------------------------------------------------
  logic [DATA_W-1:0] p_in [9];
  logic [DATA_W-1:0] nb_d [8];
  logic [CEN_W-1:0]  cen1_d;
  lap_mode_e         mode1_d;

  logic [DATA_W-1:0] nb1_q [8];
  logic [CEN_W-1:0]  cen1_q;
  lap_mode_e         mode1_q;

  // --- S2 ------------------------------------------------------------------
  logic [DATA_W-1:0] ga_a, ga_b, ga_c, ga_d;
  logic [DATA_W-1:0] gb_a, gb_b, gb_c, gb_d;
  logic [SUM_W-1:0]  suma2_q, sumb2_q;
  logic [CEN_W-1:0]  cen2_q;

  // --- S3 / S4 ---------------------------------------------------------------
  logic [CEN_W-1:0]  tot3;
  logic [OUT_W-1:0]  diff3_d;
  logic [OUT_W-1:0]  diff3_q;
  logic [RES_W-1:0]  res_d;
  logic [RES_W-1:0]  res_q;

  assign adv       = !vld_q[STAGES-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign out_data  = res_q;

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      p_in[k] = in_win[k*DATA_W +: DATA_W];
    end
  end

  // Centre is not kept as a pixel; only its scaled value travels on.
  always_comb begin
    nb_d[0] = p_in[0];
    nb_d[1] = p_in[1];
    nb_d[2] = p_in[2];
    nb_d[3] = p_in[3];
    nb_d[4] = p_in[5];
    nb_d[5] = p_in[6];
    nb_d[6] = p_in[7];
    nb_d[7] = p_in[8];
    mode1_d = lap_mode_e'(in_mode);
    if (mode1_d == LAP_MODE8) begin
      cen1_d = {p_in[4], 3'b000};
    end else begin
      cen1_d = {1'b0, p_in[4], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      cen1_q  <= '0;
      mode1_q <= LAP_MODE4;
      for (int k = 0; k < 8; k++) begin
        nb1_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q   <= {vld_q[STAGES-2:0], in_valid};
      cen1_q  <= cen1_d;
      mode1_q <= mode1_d;
      for (int k = 0; k < 8; k++) begin
        nb1_q[k] <= nb_d[k];
      end
    end
  end

  // Corners (p0, p2, p6, p8) contribute only to the 8-neighbour kernel.
  always_comb begin
    ga_a = (mode1_q == LAP_MODE8) ? nb1_q[0] : '0;
    ga_b = nb1_q[1];
    ga_c = (mode1_q == LAP_MODE8) ? nb1_q[2] : '0;
    ga_d = nb1_q[3];
    gb_a = nb1_q[4];
    gb_b = (mode1_q == LAP_MODE8) ? nb1_q[5] : '0;
    gb_c = nb1_q[6];
    gb_d = (mode1_q == LAP_MODE8) ? nb1_q[7] : '0;
  end

  laplacian_sum4 #(.DATA_W(DATA_W)) u_sum_top (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (adv),
    .a_i   (ga_a),
    .b_i   (ga_b),
    .c_i   (ga_c),
    .d_i   (ga_d),
    .sum_o (suma2_q)
  );

  laplacian_sum4 #(.DATA_W(DATA_W)) u_sum_bot (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (adv),
    .a_i   (gb_a),
    .b_i   (gb_b),
    .c_i   (gb_c),
    .d_i   (gb_d),
    .sum_o (sumb2_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cen2_q <= '0;
    end else if (adv) begin
      cen2_q <= cen1_q;
    end
  end

  // Both operands are non-negative and zero-extended; the OUT_W-bit
  // difference is therefore the exact two's-complement result.
  assign tot3    = {1'b0, suma2_q} + {1'b0, sumb2_q};
  assign diff3_d = {2'b00, cen2_q} - {2'b00, tot3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff3_q <= '0;
    end else if (adv) begin
      diff3_q <= diff3_d;
    end
  end

`ifdef LAPLACE_SAT_EN
  always_comb begin
    if (diff3_q[OUT_W-1]) begin
      res_d = '0;
    end else if (|diff3_q[OUT_W-2:DATA_W]) begin
      res_d = '1;
    end else begin
      res_d = diff3_q[DATA_W-1:0];
    end
  end
`else
  assign res_d = diff3_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (adv) begin
      res_q <= res_d;
    end
  end

endmodule

// File: tb/tb_laplacian_conv_pipe.sv
module tb_laplacian_conv_pipe;
  import laplacian_pkg::*;

  localparam int DW    = 4;
  localparam int RES_W = lap_out_w(DW);

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [9*DW-1:0]   in_win;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_data;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  int stall_cnt = 0;
  int stall_seen = 0;
  bit bp_rand = 0;
  logic [31:0] exp_q[$];

  laplacian_conv_pipe #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_win    (in_win),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [9*DW-1:0] w, input logic mode);
    int p[9];
    int r;
    logic [31:0] mask;
    for (int k = 0; k < 9; k++) p[k] = int'(w[k*DW +: DW]);
    if (mode) r = 8*p[4] - (p[0]+p[1]+p[2]+p[3]+p[5]+p[6]+p[7]+p[8]);
    else      r = 4*p[4] - (p[1]+p[3]+p[5]+p[7]);
`ifdef LAPLACE_SAT_EN
    if (r < 0) r = 0;
    if (r > (1<<DW)-1) r = (1<<DW)-1;
`endif
    mask = (32'd1 << RES_W) - 32'd1;
    return 32'(r) & mask;
  endfunction

  function automatic logic [9*DW-1:0] mk_win(input int c, input int o);
    logic [9*DW-1:0] w;
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = (k == 4) ? DW'(c) : DW'(o);
    return w;
  endfunction

  // Scoreboard: result check before push so an output never matches a
  // window accepted in the same cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("out_data", 32'(out_data), exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_win, in_mode));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else if (bp_rand) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  endtask

  task automatic drive_beat(input logic [9*DW-1:0] w, input logic mode);
    bit acc;
    int budget;
    in_valid = 1'b1;
    in_win   = w;
    in_mode  = mode;
    acc      = 1'b0;
    budget   = 0;
    while (!acc && budget < 100) begin
      @(negedge clk);
      acc = in_ready;
      if (!out_ready && out_valid) begin
        chk("in_ready_stall", {31'd0, in_ready}, 32'd0);
        stall_seen++;
      end
      if (out_ready) chk("in_ready_open", {31'd0, in_ready}, 32'd1);
      step();
      budget++;
    end
    if (!acc) chk("accept_timeout", 32'(budget), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_one(input logic [9*DW-1:0] w, input logic mode, input string tag);
    int cnt;
    drive_beat(w, mode);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 20);
    chk(tag, 32'(cnt), 32'd4);
    step();
  endtask

  task automatic drain();
    int budget;
    bp_rand   = 0;
    stall_cnt = 0;
    budget    = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      step();
      budget++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    idle(2);
  endtask

  initial begin
    int base;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_win    = '0;
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  32'(out_data), 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // flat image gives zero in both modes
    send_one(mk_win(5, 5), 1'b0, "t1_lat_m4");
    send_one(mk_win(5, 5), 1'b1, "t1_lat_m8");

    // isolated bright centre and dark centre in bright field
    send_one(mk_win(15, 0), 1'b0, "t2_lat_m4");
    send_one(mk_win(15, 0), 1'b1, "t2_lat_m8");
    send_one(mk_win(0, 15), 1'b1, "t3_lat_m8");
    send_one(mk_win(0, 15), 1'b0, "t3_lat_m4");
    drain();

    // back-to-back stream with a 3-cycle output stall
    base       = n_out;
    stall_seen = 0;
    for (int i = 0; i < 8; i++) begin
      logic [9*DW-1:0] w;
      for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'((i*7 + k*3 + i*k) % 16);
      if (i == 5) stall_cnt = 3;
      drive_beat(w, i[0]);
    end
    drain();
    chk("t4_count", 32'(n_out - base), 32'd8);
    chk("t4_stalled", {31'd0, (stall_seen > 0)}, 32'd1);

    // reset with samples in flight
    for (int i = 0; i < 3; i++) drive_beat(mk_win(9 - i, i), 1'b1);
    idle(1);
    chk("t5_pre_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_out_data",  32'(out_data), 32'd0);
    exp_q.delete();
    base = n_out;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(6);
    chk("t5_no_stale", 32'(n_out - base), 32'd0);
    send_one(mk_win(12, 3), 1'b0, "t5_lat");
    drain();

    // random windows, modes, gaps and backpressure
    base    = n_out;
    bp_rand = 1;
    for (int i = 0; i < 10000; i++) begin
      logic [9*DW-1:0] w;
      for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'($urandom_range(0, (1<<DW)-1));
      if ($urandom_range(0, 9) == 0) idle(1);
      drive_beat(w, 1'($urandom_range(0, 1)));
    end
    drain();
    chk("t6_count", 32'(n_out - base), 32'd10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
